uart_irq_service: RTL and testbench
===================================

Name: uart_irq_service

Overview:
- Bus-side consumer of the UART interrupt controller; drives that controller's register interface rather than being driven by it.
- On irq, reads the interruption status register (address 2'b11) and picks the highest-priority pending source. It hands that source ID to the local handler, then write-1-to-clears exactly that bit.
- Sits between the UART register block and the control logic that reacts to UART events (RX ready, TX empty, errors).

Parameters:
- DATA_REG_BITS, 32, width of the register data bus.
- ACK_TIMEOUT, 255, cycles to wait for vec_ack before forced clear; 0 disables the timeout.
- HOLDOFF, 2, idle cycles after a clear write before irq is sampled again (min 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- irq  input  1  interrupt request from the controller, same clock domain.
- service_en  input  1  servicing allowed; when 0, new services are not started.
- rd_data  input  DATA_REG_BITS  status read data; valid combinationally in the cycle rd=1.
- address  output  2  register address; 2'b11 during read and clear, else 2'b00.
- wr_data  output  DATA_REG_BITS  clear mask (one-hot) during the clear cycle, else 0.
- wr  output  1  one-cycle write strobe.
- rd  output  1  one-cycle read strobe.
- vec_valid  output  1  source ID presented to the handler.
- vec_id  output  3  index of the serviced source (0..7).
- vec_ack  input  1  handler done; sampled only while vec_valid=1.
- busy  output  1  1 in any state other than IDLE.
- timeout_err  output  1  sticky; set on an ack timeout, cleared only by reset.
- spurious  output  1  one-cycle pulse when a status read returns 0 in bits [7:0].
- serviced_cnt  output  16  count of completed clears; wraps 16'hFFFF -> 0.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, READ, DISPATCH, CLEAR, HOLDOFF.
- IDLE -> READ when irq=1 and service_en=1.
- READ, one cycle:
  - rd=1, address=2'b11.
  - Latch rd_data[7:0] into a pending register.
  - If the latched value is 0: pulse spurious, go to HOLDOFF.
  - Else: vec_id = lowest set bit index (bit 0 has highest priority), go to DISPATCH.
- DISPATCH:
  - vec_valid=1, vec_id stable.
  - Timeout counter counts from 0 starting on DISPATCH entry.
  - vec_ack=1 -> CLEAR on the next edge; vec_valid drops in the same edge.
  - If ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT with no ack: set timeout_err, go to CLEAR.
  - An ack in the same cycle as the timeout takes priority; timeout_err is not set.
- CLEAR, one cycle:
  - wr=1, address=2'b11, wr_data = 1<<vec_id, upper bits 0.
  - serviced_cnt increments.
  - Go to HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF cycles, then goes to IDLE.
  - Covers the one-cycle lag between the clear write and irq deasserting; prevents a stale re-read.
- Other pending bits: bits latched but not serviced are not cleared. They are re-read on the next pass, which services one source per pass.
- service_en=0 mid-service: the current service completes; only the IDLE -> READ transition is gated.
- irq deasserting after READ (e.g. the controller's mask dropped): the service still completes. The clear write is harmless.
- Only one of rd and wr is ever high in a given cycle; both are never high together.
- Asynchronous reset mid-service: immediate return to IDLE, all strobes 0. No partial write is issued after reset release.
- No combinational path from any input to rd, wr, or address. All outputs are registered or decoded from state only.

Test Plan:
- Reset, then irq=1 with rd_data=32'h0000_0014 and service_en=1 -> rd pulse at address 3; vec_valid with vec_id=2. On vec_ack: wr pulse with wr_data=32'h0000_0004, serviced_cnt=1.
- Status 0x14, model clears only the written bit; irq stays high -> second pass services vec_id=4 with wr_data=0x10, serviced_cnt=2, then idle once irq drops.
- irq=1, rd_data=0 -> spurious pulse for one cycle, no vec_valid, no wr; return to IDLE after HOLDOFF cycles.
- ACK_TIMEOUT=4, vec_ack held 0 -> clear write issued 4 cycles after DISPATCH entry, timeout_err=1 and stays 1. A separate case with ack arriving in the timeout cycle -> timeout_err stays 0.
- service_en=0 with irq=1 -> no rd for 100 cycles. Then raise service_en -> rd on the next cycle.
- Assert rst_n=0 while in DISPATCH -> vec_valid, busy, wr, and rd are 0 immediately. After release with irq=1, a fresh READ is issued.

Source files
------------

// File: rtl/uart_irq_service.sv
// Interrupt service sequencer for the UART interrupt controller: reads status,
// dispatches the highest-priority source to a handler, then W1C-clears it.
module uart_irq_service #(
    parameter int DATA_REG_BITS = 32,
    parameter int ACK_TIMEOUT   = 255,
    parameter int HOLDOFF       = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     irq,
    input  logic                     service_en,
    input  logic [DATA_REG_BITS-1:0] rd_data,
    output logic [1:0]               address,
    output logic [DATA_REG_BITS-1:0] wr_data,
    output logic                     wr,
    output logic                     rd,
    output logic                     vec_valid,
    output logic [2:0]               vec_id,
    input  logic                     vec_ack,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     spurious,
    output logic [15:0]              serviced_cnt
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HO_LAST =
        HW'((HOLDOFF > 1) ? HOLDOFF - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DISPATCH,
        S_CLEAR,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [7:0]      pending;
    logic [TW-1:0]   ack_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            to_hit;
    logic            status_zero;
    logic [7:0]      mask;
    logic            unused_hi;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    assign unused_hi   = ^rd_data[DATA_REG_BITS-1:8];
    assign status_zero = (rd_data[7:0] == 8'd0);
    assign to_hit      = (ACK_TIMEOUT != 0) && (ack_cnt == TO_LAST);

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (irq && service_en) state_n = S_READ;
            end
            S_READ: begin
                state_n = status_zero ? S_HOLD : S_DISPATCH;
            end
            S_DISPATCH: begin
                if (vec_ack || to_hit) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt == HO_LAST) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pending      <= 8'd0;
            ack_cnt      <= '0;
            hold_cnt     <= '0;
            timeout_err  <= 1'b0;
            spurious     <= 1'b0;
            serviced_cnt <= 16'd0;
        end else begin
            state    <= state_n;
            spurious <= (state == S_READ) && status_zero;
            if (state == S_READ) pending <= rd_data[7:0];
            ack_cnt  <= (state == S_DISPATCH) ? ack_cnt + 1'b1 : '0;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
            // An ack landing in the timeout cycle wins: no error flagged.
            if (state == S_DISPATCH && !vec_ack && to_hit)
                timeout_err <= 1'b1;
            if (state == S_CLEAR)
                serviced_cnt <= serviced_cnt + 16'd1;
        end
    end

    assign vec_id    = lowest(pending);
    assign mask      = 8'd1 << vec_id;
    assign rd        = (state == S_READ);
    assign wr        = (state == S_CLEAR);
    assign address   = (rd || wr) ? 2'b11 : 2'b00;
    assign wr_data   = wr ? {{(DATA_REG_BITS-8){1'b0}}, mask}
                          : '0;
    assign vec_valid = (state == S_DISPATCH);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_irq_service.sv
// Scoreboard bench for uart_irq_service: a W1C status model drives the DUT,
// expected bus/vector events are queued and a monitor pops them.
module tb_uart_irq_service;

    localparam int K_RD   = 0;
    localparam int K_VEC  = 1;
    localparam int K_WR   = 2;
    localparam int K_SPUR = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic        service_en;
    logic [31:0] rd_data;
    logic [1:0]  address;
    logic [31:0] wr_data;
    logic        wr;
    logic        rd;
    logic        vec_valid;
    logic [2:0]  vec_id;
    logic        vec_ack;
    logic        busy;
    logic        timeout_err;
    logic        spurious;
    logic [15:0] serviced_cnt;

    logic [31:0] status;
    logic        load;
    logic [31:0] load_val;
    logic        irq_lag;
    logic        irq_force;
    int          ack_delay;
    int          checks;
    int          errors;
    int          last_disp;
    int          last_busy;
    ev_t         exp_q[$];

    uart_irq_service #(
        .DATA_REG_BITS(32),
        .ACK_TIMEOUT(4),
        .HOLDOFF(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irq(irq),
        .service_en(service_en),
        .rd_data(rd_data),
        .address(address),
        .wr_data(wr_data),
        .wr(wr),
        .rd(rd),
        .vec_valid(vec_valid),
        .vec_id(vec_id),
        .vec_ack(vec_ack),
        .busy(busy),
        .timeout_err(timeout_err),
        .spurious(spurious),
        .serviced_cnt(serviced_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status register model: W1C on wr, irq follows status one cycle late.
    always @(posedge clk) begin
        if (load) status <= load_val;
        else if (wr) status <= status & ~wr_data;
        irq_lag <= |status[7:0];
    end
    assign rd_data = status;
    assign irq     = irq_lag | irq_force;

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic void push(int kind, logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(int kind, logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected kind %0d data %0h none queued",
                     kind, data);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_data", data, e.data);
        end
    endfunction

    // Handler model: ack after ack_delay cycles of vec_valid (-1: never).
    initial begin
        int cnt;
        cnt = 0;
        vec_ack = 1'b0;
        forever begin
            @(negedge clk);
            vec_ack = 1'b0;
            if (vec_valid) begin
                if (ack_delay >= 0 && cnt == ack_delay) vec_ack = 1'b1;
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        logic vv_prev;
        logic busy_prev;
        int   disp_run;
        int   busy_run;
        vv_prev = 1'b0;
        busy_prev = 1'b0;
        disp_run = 0;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd && wr) chk("rd_wr_excl", 1, 0);
                if (rd) observe(K_RD, {30'd0, address});
                if (vec_valid && !vv_prev) observe(K_VEC, {29'd0, vec_id});
                if (wr) begin
                    observe(K_WR, wr_data);
                    chk("wr_addr", {30'd0, address}, 32'd3);
                end
                if (spurious) observe(K_SPUR, 32'd0);
                if (vec_valid) begin
                    if (!vv_prev) disp_run = 0;
                    disp_run++;
                    last_disp = disp_run;
                end
                if (busy) begin
                    if (!busy_prev) busy_run = 0;
                    busy_run++;
                    last_busy = busy_run;
                end
                vv_prev = vec_valid;
                busy_prev = busy;
            end else begin
                vv_prev = 1'b0;
                busy_prev = 1'b0;
            end
        end
    end

    task automatic load_status(input logic [31:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_quiet();
        int q;
        int n;
        q = 0;
        n = 0;
        while (q < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (!busy) q++;
            else q = 0;
        end
        if (q < 8) begin
            checks++;
            errors++;
            $display("FAIL quiet_timeout got busy %0d expected idle", busy);
        end
    endtask

    task automatic wait_sig(input int which, input string name);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (which == 0 && rd) break;
            if (which == 1 && vec_valid) break;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s got no event expected one within 50", name);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_disp = 0;
        last_busy = 0;
        rst_n = 1'b0;
        service_en = 1'b1;
        load = 1'b0;
        load_val = 32'd0;
        status = 32'd0;
        irq_lag = 1'b0;
        irq_force = 1'b0;
        ack_delay = 2;

        repeat (3) @(negedge clk);
        chk("rst_strobes", {28'd0, rd, wr, vec_valid, busy}, 32'd0);
        chk("rst_address", {30'd0, address}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_flags", {30'd0, timeout_err, spurious}, 32'd0);
        chk("rst_cnt", {16'd0, serviced_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two pending sources: bit 2 first, bit 4 on the second pass.
        push(K_RD, 3); push(K_VEC, 2); push(K_WR, 32'h4);
        push(K_RD, 3); push(K_VEC, 4); push(K_WR, 32'h10);
        load_status(32'h0000_0014);
        wait_quiet();
        chk("two_pass_cnt", {16'd0, serviced_cnt}, 32'd2);
        chk("two_pass_disp", last_disp, 3);
        chk("two_pass_status", status, 32'd0);
        chk("two_pass_q", exp_q.size(), 0);

        // Spurious: irq with empty status.
        push(K_RD, 3); push(K_SPUR, 0);
        @(negedge clk);
        irq_force = 1'b1;
        wait_sig(0, "spur_rd");
        irq_force = 1'b0;
        wait_quiet();
        chk("spur_busy_len", last_busy, 3);
        chk("spur_cnt", {16'd0, serviced_cnt}, 32'd2);
        chk("spur_q", exp_q.size(), 0);

        // Ack in the timeout cycle beats the timeout.
        ack_delay = 3;
        push(K_RD, 3); push(K_VEC, 7); push(K_WR, 32'h80);
        load_status(32'h0000_0080);
        wait_quiet();
        chk("ack_at_to_err", {31'd0, timeout_err}, 32'd0);
        chk("ack_at_to_disp", last_disp, 4);
        chk("ack_at_to_cnt", {16'd0, serviced_cnt}, 32'd3);

        // No ack: forced clear after 4 dispatch cycles.
        ack_delay = -1;
        push(K_RD, 3); push(K_VEC, 0); push(K_WR, 32'h1);
        load_status(32'h0000_0001);
        wait_quiet();
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_disp", last_disp, 4);
        chk("to_cnt", {16'd0, serviced_cnt}, 32'd4);
        ack_delay = 0;
        push(K_RD, 3); push(K_VEC, 1); push(K_WR, 32'h2);
        load_status(32'h0000_0002);
        wait_quiet();
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("fast_ack_disp", last_disp, 1);
        chk("fast_ack_cnt", {16'd0, serviced_cnt}, 32'd5);

        // service_en gates the start of a service.
        service_en = 1'b0;
        ack_delay = 1;
        load_status(32'h0000_0008);
        repeat (100) begin
            @(negedge clk);
            if (rd) break;
        end
        chk("gated_busy", {31'd0, busy}, 32'd0);
        push(K_RD, 3); push(K_VEC, 3); push(K_WR, 32'h8);
        service_en = 1'b1;
        @(negedge clk);
        chk("en_rd_next", {31'd0, rd}, 32'd1);
        wait_quiet();
        chk("en_cnt", {16'd0, serviced_cnt}, 32'd6);

        // Reset while dispatching, then a fresh service.
        ack_delay = -1;
        push(K_RD, 3); push(K_VEC, 5);
        load_status(32'h0000_0020);
        wait_sig(1, "rst_vec");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_strobes", {28'd0, rd, wr, vec_valid, busy}, 32'd0);
        chk("arst_cnt", {16'd0, serviced_cnt}, 32'd0);
        chk("arst_q", exp_q.size(), 0);
        @(negedge clk);
        ack_delay = 0;
        push(K_RD, 3); push(K_VEC, 5); push(K_WR, 32'h20);
        rst_n = 1'b1;
        wait_quiet();
        chk("post_rst_cnt", {16'd0, serviced_cnt}, 32'd1);
        chk("post_rst_err", {31'd0, timeout_err}, 32'd0);
        chk("final_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
